// File: rtl/card_pkg.sv
// Shared card geometry and colour constants for the sprite drawing pipeline.
package card_pkg;
    typedef logic [2:0] color_t;

    localparam int CARD_W = 16;
    localparam int CARD_H = 32;
    localparam int COL_W  = $clog2(CARD_W);
    localparam int ROW_W  = $clog2(CARD_H);
    localparam int ADDR_W = COL_W + ROW_W;

    localparam color_t TRANSP_COLOR = 3'b000;
    localparam color_t BACK_COLOR_A = 3'b001;
    localparam color_t BACK_COLOR_B = 3'b100;
    localparam color_t HILITE_COLOR = 3'b110;
endpackage

// File: rtl/card_sprite_draw_if.sv
// Read port of the card image memory: address/enable out, registered texel back.
interface card_sprite_draw_if;
    import card_pkg::*;

    logic                RE;
    logic [ADDR_W-1:0]   rAddr;
    color_t              dataOut;

    modport master (output RE, output rAddr, input dataOut);
    modport slave  (input RE, input rAddr, output dataOut);
endinterface

// File: rtl/card_hit_calc.sv
// Combinational card-relative offset, coverage test and border detection for one pixel.
module card_hit_calc
    import card_pkg::*;
(
    input  logic [7:0]       pixelX,
    input  logic [7:0]       pixelY,
    input  logic             pixelValid,
    input  logic [7:0]       posX,
    input  logic [7:0]       posY,
    output logic             hit,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             border
);
    logic [8:0] dx;
    logic [8:0] dy;

    // 9-bit differences: bit 8 set means the pixel lies left of/above the card, so no wrap-around.
    always_comb begin
        dx     = {1'b0, pixelX} - {1'b0, posX};
        dy     = {1'b0, pixelY} - {1'b0, posY};
        hit    = pixelValid & ~dx[8] & (dx < 9'(CARD_W)) & ~dy[8] & (dy < 9'(CARD_H));
        col    = dx[COL_W-1:0];
        row    = dy[ROW_W-1:0];
        border = (col == '0) | (col == COL_W'(CARD_W - 1)) |
                 (row == '0) | (row == ROW_W'(CARD_H - 1));
    end
endmodule

// File: rtl/card_sprite_draw.sv
// Three-stage card sprite pipeline: address generation, memory wait, colour select.
module card_sprite_draw
    import card_pkg::*;
(
    input  logic               clock,
    input  logic               resetN,
    input  logic               frameStart,
    input  logic [7:0]         cardX,
    input  logic [7:0]         cardY,
    input  logic               faceDown,
    input  logic               selected,
    input  logic [7:0]         pixelX,
    input  logic [7:0]         pixelY,
    input  logic               pixelValid,
    card_sprite_draw_if.master mem,
    output color_t             pixelOut,
    output logic               pixelOn
);
    logic [7:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic              fd_q, fd_d, sel_q, sel_d;

    logic              hit_p0, border_p0;
    logic [COL_W-1:0]  col_p0;
    logic [ROW_W-1:0]  row_p0;

    logic              re_q, re_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic              hit_p1_q, hit_p1_d, border_p1_q, border_p1_d;
    logic              fd_p1_q, fd_p1_d, sel_p1_q, sel_p1_d;
    logic [COL_W-1:0]  col_p1_q, col_p1_d;
    logic [ROW_W-1:0]  row_p1_q, row_p1_d;

    logic              hit_p2_q, hit_p2_d, border_p2_q, border_p2_d;
    logic              fd_p2_q, fd_p2_d, sel_p2_q, sel_p2_d;
    logic [COL_W-1:0]  col_p2_q, col_p2_d;
    logic [ROW_W-1:0]  row_p2_q, row_p2_d;

    color_t            pixel_out_q, pixel_out_d;
    logic              pixel_on_q, pixel_on_d;

    // Stage 0: combinational bounds check against the frame-latched placement
    card_hit_calc u_hit_calc (
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .pixelValid (pixelValid),
        .posX       (pos_x_q),
        .posY       (pos_y_q),
        .hit        (hit_p0),
        .col        (col_p0),
        .row        (row_p0),
        .border     (border_p0)
    );

    always_comb begin
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        fd_d        = fd_q;
        sel_d       = sel_q;
        if (frameStart) begin
            pos_x_d = cardX;
            pos_y_d = cardY;
            fd_d    = faceDown;
            sel_d   = selected;
        end

        // Stage 1: issue memory read; address holds between hits
        re_d        = hit_p0;
        r_addr_d    = hit_p0 ? {row_p0, col_p0} : r_addr_q;
        hit_p1_d    = hit_p0;
        col_p1_d    = col_p0;
        row_p1_d    = row_p0;
        border_p1_d = border_p0;
        fd_p1_d     = fd_q;
        sel_p1_d    = sel_q;

        // Stage 2: travel alongside the memory's registered read
        hit_p2_d    = hit_p1_q;
        col_p2_d    = col_p1_q;
        row_p2_d    = row_p1_q;
        border_p2_d = border_p1_q;
        fd_p2_d     = fd_p1_q;
        sel_p2_d    = sel_p1_q;

        // Stage 3: colour select, border over back pattern over texel
        pixel_on_d  = 1'b0;
        pixel_out_d = '0;
        if (hit_p2_q) begin
            if (sel_p2_q && border_p2_q) begin
                pixel_on_d  = 1'b1;
                pixel_out_d = HILITE_COLOR;
            end else if (fd_p2_q) begin
                pixel_on_d  = 1'b1;
                pixel_out_d = (col_p2_q[1] ^ row_p2_q[1]) ? BACK_COLOR_B : BACK_COLOR_A;
            end else if (mem.dataOut != TRANSP_COLOR) begin
                pixel_on_d  = 1'b1;
                pixel_out_d = mem.dataOut;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            fd_q        <= 1'b0;
            sel_q       <= 1'b0;
            re_q        <= 1'b0;
            r_addr_q    <= '0;
            hit_p1_q    <= 1'b0;
            hit_p2_q    <= 1'b0;
            pixel_out_q <= '0;
            pixel_on_q  <= 1'b0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            fd_q        <= fd_d;
            sel_q       <= sel_d;
            re_q        <= re_d;
            r_addr_q    <= r_addr_d;
            hit_p1_q    <= hit_p1_d;
            hit_p2_q    <= hit_p2_d;
            pixel_out_q <= pixel_out_d;
            pixel_on_q  <= pixel_on_d;
        end
    end

    // Payload fields are qualified by the hit bits and need no reset
    always_ff @(posedge clock) begin
        col_p1_q    <= col_p1_d;
        row_p1_q    <= row_p1_d;
        border_p1_q <= border_p1_d;
        fd_p1_q     <= fd_p1_d;
        sel_p1_q    <= sel_p1_d;
        col_p2_q    <= col_p2_d;
        row_p2_q    <= row_p2_d;
        border_p2_q <= border_p2_d;
        fd_p2_q     <= fd_p2_d;
        sel_p2_q    <= sel_p2_d;
    end

    assign mem.RE    = re_q;
    assign mem.rAddr = r_addr_q;
    assign pixelOut  = pixel_out_q;
    assign pixelOn   = pixel_on_q;
endmodule

// File: tb/tb_card_sprite_draw.sv
// Randomised and directed bench for card_sprite_draw against a behavioural pixel model.
module tb_card_sprite_draw;
    import card_pkg::*;

    logic       clock = 1'b0;
    logic       resetN, frameStart, faceDown, selected, pixelValid;
    logic [7:0] cardX, cardY, pixelX, pixelY;
    color_t     pixelOut;
    logic       pixelOn;

    card_sprite_draw_if mem_if ();

    card_sprite_draw dut (
        .clock      (clock),
        .resetN     (resetN),
        .frameStart (frameStart),
        .cardX      (cardX),
        .cardY      (cardY),
        .faceDown   (faceDown),
        .selected   (selected),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .pixelValid (pixelValid),
        .mem        (mem_if),
        .pixelOut   (pixelOut),
        .pixelOn    (pixelOn)
    );

    always #5 clock = ~clock;

    // Card image memory with a one-cycle registered read
    color_t img [512];
    always @(posedge clock) if (mem_if.RE) mem_if.dataOut <= img[mem_if.rAddr];

    typedef struct { logic on; logic [2:0] col; } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int m_posx, m_posy, m_addr;
    logic m_fd, m_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // What the pixel should look like, straight from the drawing rules
    function automatic exp_t model(input int x, input int y, input logic v,
                                   output logic hit, output int addr);
        exp_t e;
        int col, row;
        e.on = 1'b0; e.col = 3'b000; addr = 0;
        hit = v && x >= m_posx && x < m_posx + CARD_W && y >= m_posy && y < m_posy + CARD_H;
        if (hit) begin
            col  = x - m_posx;
            row  = y - m_posy;
            addr = row * CARD_W + col;
            if (m_sel && (col == 0 || col == CARD_W - 1 || row == 0 || row == CARD_H - 1)) begin
                e.on = 1'b1; e.col = HILITE_COLOR;
            end else if (m_fd) begin
                e.on = 1'b1;
                e.col = (((col / 2) + (row / 2)) % 2 == 1) ? BACK_COLOR_B : BACK_COLOR_A;
            end else if (img[addr] != TRANSP_COLOR) begin
                e.on = 1'b1; e.col = img[addr];
            end
        end
        return e;
    endfunction

    task automatic step(input int x, input int y, input logic v, input logic fs);
        exp_t e;
        logic hit;
        int addr;
        pixelX = 8'(x); pixelY = 8'(y); pixelValid = v; frameStart = fs;
        e = model(x, y, v, hit, addr);
        if (hit) m_addr = addr;
        q.push_back(e);
        if (fs) begin
            m_posx = cardX; m_posy = cardY; m_fd = faceDown; m_sel = selected;
        end
        @(posedge clock);
        @(negedge clock);
        frameStart = 1'b0;
        chk("re", mem_if.RE, hit);
        chk("raddr", mem_if.rAddr, m_addr);
        if (q.size() == 3) begin
            e = q.pop_front();
            chk("pixel_on", pixelOn, e.on);
            chk("pixel_out", pixelOut, e.col);
        end
    endtask

    task automatic place(input int x, input int y, input logic fd, input logic sel);
        cardX = 8'(x); cardY = 8'(y); faceDown = fd; selected = sel;
        step(0, 0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        exp_t off;
        off.on = 1'b0; off.col = 3'b000;
        resetN = 1'b0;
        frameStart = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_on", pixelOn, 0);
        chk("rst_out", pixelOut, 0);
        chk("rst_re", mem_if.RE, 0);
        chk("rst_raddr", mem_if.rAddr, 0);
        resetN = 1'b1;
        m_posx = 0; m_posy = 0; m_fd = 1'b0; m_sel = 1'b0; m_addr = 0;
        q.delete();
        q.push_back(off);
        q.push_back(off);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        resetN = 1'b0; frameStart = 1'b0; pixelValid = 1'b0;
        cardX = '0; cardY = '0; faceDown = 1'b0; selected = 1'b0;
        pixelX = '0; pixelY = '0;
        for (int i = 0; i < 512; i++) img[i] = color_t'($urandom);
        img[53] = 3'b010;
        img[35] = TRANSP_COLOR;

        do_reset();

        // Card at origin, pixel (5,3)
        step(5, 3, 1'b1, 1'b0);
        chk("addr53", mem_if.rAddr, 53);
        step(0, 0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0);
        chk("texel53", pixelOut, 3'b010);

        // Horizontal scan across a placed card
        place(100, 50, 1'b0, 1'b0);
        for (int x = 98; x <= 118; x++) step(x, 50, 1'b1, 1'b0);
        flush();

        // Right/bottom clipping, no wrap
        place(250, 230, 1'b0, 1'b0);
        step(0, 230, 1'b1, 1'b0);
        step(253, 239, 1'b1, 1'b0);
        chk("addr147", mem_if.rAddr, 147);
        flush();

        // Transparent texel, then the same pixel face-down
        place(20, 20, 1'b0, 1'b0);
        step(23, 22, 1'b1, 1'b0);
        flush();
        place(20, 20, 1'b1, 1'b0);
        step(23, 22, 1'b1, 1'b0);
        flush();

        // Selection border over back pattern, interior unaffected
        place(10, 10, 1'b1, 1'b1);
        step(10, 20, 1'b1, 1'b0);
        step(12, 20, 1'b1, 1'b0);
        flush();
        place(10, 10, 1'b0, 1'b1);
        step(10, 20, 1'b1, 1'b0);
        step(12, 20, 1'b1, 1'b0);

        // Mid-frame input change, then frameStart together with a valid pixel
        cardX = 8'd200; cardY = 8'd0;
        step(12, 20, 1'b1, 1'b0);
        step(12, 20, 1'b1, 1'b1);
        step(12, 20, 1'b1, 1'b0);
        flush();

        // Reset with hits in flight
        place(10, 10, 1'b0, 1'b0);
        step(11, 11, 1'b1, 1'b0);
        step(12, 11, 1'b1, 1'b0);
        pixelValid = 1'b1;
        do_reset();
        flush();

        // Randomised pixels near randomly placed cards
        for (int n = 0; n < 4000; n++) begin
            int x, y;
            logic v, fs;
            if ($urandom_range(0, 799) == 0) begin
                pixelValid = 1'($urandom);
                do_reset();
            end
            fs = ($urandom_range(0, 47) == 0);
            cardX = 8'($urandom); cardY = 8'($urandom_range(0, 239));
            faceDown = 1'($urandom); selected = 1'($urandom);
            x = (m_posx + $urandom_range(0, 23) - 4) & 255;
            y = (m_posy + $urandom_range(0, 39) - 4 + 240) % 240;
            v = ($urandom_range(0, 9) != 0);
            step(x, y, v, fs);
        end
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/card_sprite_draw.md
Name: card_sprite_draw

Overview:
- Downstream consumer of a card image memory (512 x 3-bit, 16 wide x 32 tall, row-major, 1-cycle registered read).
- Takes the VGA pixel stream coordinates (256x240) and the frame-latched card placement, and generates the memory read address.
- Aligns the returned texel with its pixel and emits a 3-bit colour plus a coverage flag to the pixel mux.
- Supports transparency keying, a face-down back pattern and a selection border.

Parameters:
CARD_W, 16, card width in pixels (power of 2; address column bits = log2)
CARD_H, 32, card height in pixels (CARD_W*CARD_H = memory depth 512)
TRANSP_COLOR, 3'b000, texel value treated as transparent
BACK_COLOR_A, 3'b001, face-down checker colour when (col[1]^row[1])=0
BACK_COLOR_B, 3'b100, face-down checker colour when (col[1]^row[1])=1
HILITE_COLOR, 3'b110, selection border colour

Ports:
clock  in  1  system clock, all logic on rising edge
resetN  in  1  synchronous active-low reset
frameStart  in  1  one-cycle pulse at start of vertical blank; latches placement inputs
cardX  in  8  card left edge, pixels
cardY  in  8  card top edge, pixels
faceDown  in  1  draw back pattern instead of image
selected  in  1  draw 1-pixel border in HILITE_COLOR
pixelX  in  8  current pixel column 0..255
pixelY  in  8  current pixel row 0..239
pixelValid  in  1  pixelX/pixelY are an active-area pixel this cycle
RE  out  1  read enable to card memory
rAddr  out  9  read address to card memory
dataOut  in  3  card memory read data (valid one cycle after rAddr)
pixelOut  out  3  colour for the aligned pixel
pixelOn  out  1  card covers the aligned pixel (opaque)

Behaviour:
- Placement regs posX, posY, fd, sel load from cardX, cardY, faceDown, selected only on a clock edge where frameStart=1. Reset: 0, 0, 0, 0. Mid-frame changes to the inputs have no effect until the next frameStart.
- Stage 0 (comb): dx = {1'b0,pixelX} - {1'b0,posX} and dy = {1'b0,pixelY} - {1'b0,posY}, both 9-bit. hit0 = pixelValid & ~dx[8] & (dx < CARD_W) & ~dy[8] & (dy < CARD_H). No wrap-around: a card at x=250 is clipped at column 255 and never appears at x=0..9.
- Edge 1:
  - rAddr <= {dy[4:0], dx[3:0]} when hit0, else holds its previous value.
  - RE <= hit0.
  - Register hit1, col1 = dx[3:0], row1 = dy[4:0], border1 = (col==0 | col==CARD_W-1 | row==0 | row==CARD_H-1), fd1, sel1.
- Edge 2: the memory presents dataOut. The block advances hit2/col2/row2/border2/fd2/sel2.
- Edge 3: output register selects, in priority order:
  - ~hit2 -> pixelOn=0, pixelOut=0
  - sel2 & border2 -> HILITE_COLOR, on
  - fd2 -> BACK_A/B by col2[1]^row2[1], on
  - dataOut==TRANSP_COLOR -> pixelOn=0, pixelOut=0
  - else dataOut, on
- Latency: exactly 3 clocks from pixel sample to pixelOut/pixelOn. The block is fully pipelined and accepts one pixel per clock with no stalls.
- Reset values: RE=0, rAddr=0, pixelOut=0, pixelOn=0, all pipeline valid bits 0.
- Reset mid-line: all in-flight pixels are discarded, and outputs are 0 on the cycle after reset is sampled.
- frameStart coinciding with pixelValid: that pixel uses the old placement and the next pixel uses the new one.
- The memory write port is not driven by this block.

Decomposition:
- Package card_pkg: CARD_W, CARD_H, the colour constants, and a typedef color_t = logic [2:0].
- Optional sub-module card_hit_calc: stage-0 bounds/address/border logic, purely combinational. All state lives in the top module.

Test Plan:
- Reset then posX=0/posY=0, pixel (5,3) valid -> rAddr=53 one clock later, RE=1; memory returns 3'b010 -> pixelOut=3'b010, pixelOn=1 three clocks after the input.
- frameStart with cardX=100, cardY=50; scan row 50, x=98..118 -> RE high exactly for x=100..115; pixelOn low for x=98,99,116..118 with 3-cycle alignment.
- cardX=250, cardY=230; pixels (0,230) and (253,239) -> first not hit; second hit with rAddr={5'd9,4'd3}=147; clipping with no wrap.
- Texel =TRANSP_COLOR at an in-bounds pixel -> pixelOn=0, pixelOut=0; same pixel with faceDown=1 latched -> checker colour, pixelOn=1.
- selected=1 latched, card at (10,10); pixel (10,20) -> HILITE_COLOR regardless of faceDown; pixel (12,20) -> texel or back colour.
- cardX changed mid-frame without frameStart -> output unchanged. Assert resetN=0 while a hit is in flight -> pixelOn=0 next clock and no stale pixel emitted after release.
